// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI response codes shared by AXI-Lite blocks
package axi_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_reg_responder_pkg.sv
// rtl/axil_reg_responder_pkg.sv - states, grant and reg-interface structs for the responder
package axil_reg_responder_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        WR_RESP = 3'd3,
        RD_RESP = 3'd4
    } state_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grant_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI-Lite channel bundle with subordinate-side modport
interface AXI_LITE #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]                aw_prot;
    logic                      aw_valid;
    logic                      aw_ready;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_valid;
    logic                      w_ready;
    logic [1:0]                b_resp;
    logic                      b_valid;
    logic                      b_ready;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]                ar_prot;
    logic                      ar_valid;
    logic                      ar_ready;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_valid;
    logic                      r_ready;

    modport Slave (
        input  aw_addr, aw_prot, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_addr, ar_prot, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axil_reg_responder_watchdog.sv
// rtl/axil_reg_responder_watchdog.sv - cycle counter that flags a hung reg transaction
module axil_reg_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit means the watchdog never fires.
    assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/axil_reg_responder.sv
// rtl/axil_reg_responder.sv - AXI-Lite subordinate issuing single reg-interface transactions
module axil_reg_responder
    import axi_pkg::*;
    import axil_reg_responder_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter type         req_t          = reg_req_t,
    parameter type         rsp_t          = reg_rsp_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    AXI_LITE.Slave axil_slv,
    output req_t   reg_req_o,
    input  rsp_t   reg_rsp_i
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    logic                      aw_full_q, w_full_q, ar_full_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]         w_strb_q;

    state_e                    state_q, state_d;
    grant_e                    last_grant_q, last_grant_d;
    logic                      err_q, err_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic aw_hs, w_hs, ar_hs;
    logic consume_wr, consume_rd;
    logic write_pend, read_pend;
    logic in_req, wd_expired;

    assign aw_hs = axil_slv.aw_valid && !aw_full_q;
    assign w_hs  = axil_slv.w_valid  && !w_full_q;
    assign ar_hs = axil_slv.ar_valid && !ar_full_q;

    assign write_pend = aw_full_q && w_full_q;
    assign read_pend  = ar_full_q;
    assign in_req     = (state_q == WR_REQ) || (state_q == RD_REQ);

    axil_reg_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (!in_req),
        .en_i     (in_req && !reg_rsp_i.ready),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        consume_wr   = 1'b0;
        consume_rd   = 1'b0;
        case (state_q)
            IDLE: begin
                // Round-robin only matters under contention; a lone request never moves last_grant.
                if (write_pend && read_pend) begin
                    if (last_grant_q == READ) begin
                        state_d      = WR_REQ;
                        last_grant_d = WRITE;
                    end else begin
                        state_d      = RD_REQ;
                        last_grant_d = READ;
                    end
                end else if (write_pend) begin
                    state_d = WR_REQ;
                end else if (read_pend) begin
                    state_d = RD_REQ;
                end
            end
            WR_REQ: begin
                if (reg_rsp_i.ready) begin
                    err_d      = reg_rsp_i.error;
                    consume_wr = 1'b1;
                    state_d    = WR_RESP;
                end else if (wd_expired) begin
                    err_d      = 1'b1;
                    rdata_d    = '0;
                    consume_wr = 1'b1;
                    state_d    = WR_RESP;
                end
            end
            RD_REQ: begin
                if (reg_rsp_i.ready) begin
                    err_d      = reg_rsp_i.error;
                    rdata_d    = reg_rsp_i.rdata;
                    consume_rd = 1'b1;
                    state_d    = RD_RESP;
                end else if (wd_expired) begin
                    err_d      = 1'b1;
                    rdata_d    = '0;
                    consume_rd = 1'b1;
                    state_d    = RD_RESP;
                end
            end
            WR_RESP: begin
                if (axil_slv.b_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_RESP: begin
                if (axil_slv.r_ready) begin
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= READ;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Buffers free up when the reg side finishes, so new requests overlap the B/R phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_full_q <= 1'b0;
            ar_addr_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= axil_slv.aw_addr;
            end else if (consume_wr) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= axil_slv.w_data;
                w_strb_q <= axil_slv.w_strb;
            end else if (consume_wr) begin
                w_full_q <= 1'b0;
            end
            if (ar_hs) begin
                ar_full_q <= 1'b1;
                ar_addr_q <= axil_slv.ar_addr;
            end else if (consume_rd) begin
                ar_full_q <= 1'b0;
            end
        end
    end

    always_comb begin
        reg_req_o = '0;
        if (state_q == WR_REQ) begin
            reg_req_o.valid = 1'b1;
            reg_req_o.write = 1'b1;
            reg_req_o.addr  = aw_addr_q;
            reg_req_o.wdata = w_data_q;
            reg_req_o.wstrb = w_strb_q;
        end else if (state_q == RD_REQ) begin
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = ar_addr_q;
        end
    end

    assign axil_slv.aw_ready = !aw_full_q;
    assign axil_slv.w_ready  = !w_full_q;
    assign axil_slv.ar_ready = !ar_full_q;
    assign axil_slv.b_valid  = (state_q == WR_RESP);
    assign axil_slv.b_resp   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axil_slv.r_valid  = (state_q == RD_RESP);
    assign axil_slv.r_resp   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axil_slv.r_data   = rdata_q;

endmodule
